uart_tx_fifo_reader: RTL
========================

# uart_tx_fifo_reader

Read side of the byte FIFO: pops bytes from the FIFO read port and sends each one on a UART line as 8N1, LSB first. It sits between the FIFO and the `tx` pin, so the FIFO's writer can queue bytes at clock speed while this block drains them at the baud rate. It runs a self-contained baud counter, so a byte's serialization does not depend on FIFO activity once the byte is latched.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate.
- Derived `TICKS = CLK_FREQ/BAUD`: clocks per bit. Must be ≥ 2.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: one clock; reset is asynchronous and active-low.
- `fifo_empty`, input, 1: FIFO empty flag.
- `fifo_rdata`, input, 8: FIFO head data. First-word-fall-through: valid whenever `fifo_empty=0`.
- `fifo_rd`, output, 1: pop strobe, one cycle wide.
- `tx`, output, 1: serial line, idles high.
- `tx_busy`, output, 1: high while a frame is in progress (state ≠ IDLE).
- `tx_done`, output, 1: one-cycle pulse in the last cycle of a stop bit.

## Operation
- States:
  - IDLE: `tx=1`.
  - START: `tx=0`, lasts TICKS clocks.
  - DATA: 8 bits, each TICKS clocks, `tx=shift[0]`, shift right after each bit.
  - STOP: `tx=1`, lasts TICKS clocks.
- Pop: `fifo_rd = (state==IDLE || last cycle of STOP) && !fifo_empty`. This is combinational from state and `fifo_empty`.
- Latch: in the cycle `fifo_rd=1`, `fifo_rdata` is captured into the shift register at the clock edge. The next state is START.
- Back-to-back: if the FIFO is non-empty in the last STOP cycle, the next START follows with no idle gap.
- If the FIFO is empty at the end of STOP, the next state is IDLE.
- `fifo_empty`/`fifo_rdata` are ignored in all other cycles. Changes to `fifo_rdata` mid-frame have no effect.
- Bit counter: 3 bits, counts 0..7 in DATA.
- Tick counter: width `$clog2(TICKS)`. Cleared on every state change; wraps at TICKS-1.
- `tx` is registered, so it is glitch-free.

## Timing
- Reset values: `tx=1`, `fifo_rd=0`, `tx_busy=0`, `tx_done=0`, state IDLE, all counters 0.
- Pop to line latency: with a pop in cycle N, `tx` falls at the edge ending cycle N, i.e. it is low from cycle N+1.
- Frame length: exactly 10·TICKS clocks from `tx` falling to the end of STOP.
- `tx_done`: asserted in cycle N+10·TICKS, concurrent with the optional next `fifo_rd`.
- `tx_busy`: rises at N+1. It stays high through back-to-back frames and falls one cycle after the final `tx_done`.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronous) and state returns to IDLE. The byte in flight is dropped and not re-popped. After release, normal operation resumes on the next non-empty cycle.
- `fifo_empty` deasserting in the same cycle as reset release: the pop happens no earlier than the first clock edge after release.

## Structure
- Shared package `uart_pkg`:
  - State encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - `UART_DATA_BITS=8`.
  - A `ticks_per_bit(CLK_FREQ,BAUD)` function.
- Sub-module `baud_tick_gen`:
  - Parameter: TICKS.
  - Inputs: `clk`, `reset`, `clear`.
  - Output: `tick`, which pulses in the last cycle of each bit period.
- The FSM, shift register and bit counter live in the top module.

## Test plan
All scenarios use CLK_FREQ=100, BAUD=10, so TICKS=10.
- Reset: hold `reset=0` with `fifo_empty=0` → `tx=1`, `fifo_rd=0`, `tx_busy=0` throughout. Asserting reset mid-operation forces `tx=1` without waiting for a clock.
- Single byte: present 8'hAA with `fifo_empty` falling at cycle 0 → `fifo_rd` high only in cycle 0. `tx` is then 0 (start), 0,1,0,1,0,1,0,1, 1 (stop), each held 10 clocks. `tx_done` pulses at cycle 100.
- Back-to-back: queue 8'hAA then 8'h55 → second `fifo_rd` coincides with the first `tx_done` at cycle 100. The second start bit begins at cycle 101 with no gap. `tx` for the second frame is 0,1,0,1,0,1,0,1,0,1. `tx_busy` is continuous from 1 to 200.
- Empty FIFO: hold `fifo_empty=1` for 500 cycles → no `fifo_rd`, `tx=1`, `tx_busy=0`.
- Data stability: change `fifo_rdata` to 8'hFF one cycle after popping 8'h3C → the line still carries 8'h3C, with bits 0,0,1,1,1,1,0,0.
- Reset mid-frame: assert reset during data bit 3 of 8'hAA with a second byte 8'h55 queued → `tx=1` at once. After release, exactly one `fifo_rd` occurs and a complete 8'h55 frame follows; 8'hAA is not retransmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding, data width and baud divider helper.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS = 8;

  function automatic int unsigned ticks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: tick pulses in the last clock of each TICKS-long bit period.
module baud_tick_gen #(
  parameter int unsigned TICKS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = (TICKS > 2) ? $clog2(TICKS) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == W'(TICKS - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// Drains a first-word-fall-through byte FIFO onto an 8N1 UART line, LSB first.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_rd,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned TICKS = ticks_per_bit(CLK_FREQ, BAUD);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic                      tx_q, tx_d;
  logic                      tick;
  logic                      tick_clear;
  logic                      pop;

  // The bit-period counter restarts on every state change and stays parked while idle.
  assign tick_clear = (state_d != state_q) || (state_q == StIdle);

  baud_tick_gen #(
    .TICKS (TICKS)
  ) u_baud_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
    tx_done   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick) begin
          tx_done = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the upcoming cycle, registered so tx never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  // Gated by reset so no pop is requested while the FSM is held.
  assign fifo_rd = pop & reset;
  assign tx      = tx_q;
  assign tx_busy = (state_q != StIdle);

endmodule
